parity_tx: RTL and testbench
============================

PARITY_TX -- requirements
Module: parity_tx

Interface
REQ-001 Parameter ODD_PAR, default 1, 1 selects odd parity and 0 selects even parity for the generated bit 7.
REQ-002 Parameter BAUD_DIV, default 4, sets clock cycles per serial bit; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_data  input  7  data bits [6:0] to be framed.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 tx  output  1  serial line, idle high, registered.
REQ-009 tx_busy  output  1  high while a frame is on the line.
REQ-010 frame_done  output  1  one-cycle pulse on the last cycle of the stop bit.
REQ-011 frame_cnt  output  16  frames completed; exists only when PARITY_TX_FRAME_CNT_EN is defined.

Function
REQ-012 Accept on the rising edge where in_valid=1 and in_ready=1; capture in_data and the computed parity bit into a holding register in that same edge.
REQ-013 Parity bit p: ODD_PAR=1 -> p = NOT(XOR of in_data[6:0]), so ones in {p,data} are odd; ODD_PAR=0 -> p = XOR of in_data[6:0], so ones are even.
REQ-014 Frame order: start bit 0, in_data[0] through in_data[6] LSB first, p, stop bit 1; 10 bits total, each held exactly BAUD_DIV cycles.
REQ-015 tx shall drive the start bit from the cycle after the accepting edge; frame occupies exactly 10*BAUD_DIV cycles.
REQ-016 States: IDLE -> START on accept; START -> DATA after BAUD_DIV cycles; DATA -> PARITY after 7 bit-times; PARITY -> STOP after 1 bit-time; STOP -> IDLE after 1 bit-time.
REQ-017 in_ready = 1 only in IDLE; tx_busy = 1 in START, DATA, PARITY, STOP.
REQ-018 frame_done = 1 only in the final cycle of STOP; tx stays 1 on return to IDLE.
REQ-019 in_valid or in_data changes while busy shall be ignored and shall not alter the frame in flight.
REQ-020 Back-to-back: a word presented with in_valid held high is accepted in the first IDLE cycle; minimum gap between stop bit end and next start bit is one idle cycle (tx=1).
REQ-021 Bit-time counter width is ceil(log2(BAUD_DIV+1)); BAUD_DIV=1 gives one cycle per bit with no counter wrap hazards.

Reset
REQ-022 rst_n=0 at any edge, including mid-frame: state=IDLE, tx=1, tx_busy=0, in_ready=1 after release, frame_done=0, holding register=0, bit counters=0; any partial frame is dropped.
REQ-023 in_ready shall be 0 in cycles where rst_n=0 is sampled.

Configuration
REQ-024 Macro PARITY_TX_FRAME_CNT_EN defined: 16-bit frame_cnt port present, reset to 0, increments on each frame_done, wraps 65535 -> 0.
REQ-025 Macro PARITY_TX_FRAME_CNT_EN undefined: frame_cnt port and counter absent; all other behaviour identical.

Verification
REQ-026 ODD_PAR=1, BAUD_DIV=1, send 7'h01 -> tx sequence 0,1,0,0,0,0,0,0,0,1 then idle 1; frame_done once at cycle 10 after accept.
REQ-027 ODD_PAR=1, send 7'h00 -> parity bit 1; ODD_PAR=0, send 7'h03 -> parity bit 0; send 7'h7F with ODD_PAR=0 -> parity bit 1.
REQ-028 BAUD_DIV=4, in_valid held high with 7'h55 then 7'h2A -> each bit 4 cycles, frames 40 cycles, exactly one idle cycle between, in_ready low throughout each frame.
REQ-029 rst_n pulsed low during data bit 3 -> tx=1 on next edge, tx_busy=0, no frame_done; next accepted word transmits a complete correct frame.
REQ-030 in_valid pulses with different data while busy -> ignored; line shows only the originally accepted word.
REQ-031 With PARITY_TX_FRAME_CNT_EN, send 3 frames -> frame_cnt=3; preload by 65536 frames (or force) -> wraps to 0.

Source files
------------

// File: rtl/parity_tx.sv
// ---------------------------------------------------------------------------
// parity_tx -- serial transmitter for 7-bit words with one parity bit.
//
// Frame on tx (LSB first):
//   start(0), d[0] .. d[6], parity, stop(1)
// Every bit is held for BAUD_DIV clock cycles, so a frame lasts
// 10*BAUD_DIV cycles. The line idles high.
//
// Parameters
//   ODD_PAR  : 1 = odd parity over {p, data}, 0 = even parity
//   BAUD_DIV : clock cycles per serial bit, 1..65535
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : upstream offers in_data this cycle
//   in_data    : 7-bit word to send
//   in_ready   : high only when idle (and not in reset); accept = valid & ready
//   tx         : registered serial line output
//   tx_busy    : registered, high while a frame is on the line
//   frame_done : registered one-cycle pulse in the last cycle of the stop bit
//   frame_cnt  : completed-frame counter, 16 bits, wraps
//                (present only when PARITY_TX_FRAME_CNT_EN is defined)
// ---------------------------------------------------------------------------
module parity_tx #(
  parameter int ODD_PAR  = 1,
  parameter int BAUD_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [6:0] in_data,
  output logic       in_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       frame_done
`ifdef PARITY_TX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  // Bit-time counter counts 0 .. BAUD_DIV-1 within each serial bit.
  localparam int            CW        = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] baud_r;
  logic [CW-1:0] baud_s;
  logic [2:0]    bit_r;
  logic [2:0]    bit_s;
  logic [7:0]    hold_r;     // {parity, data}
  logic [7:0]    hold_s;
  logic          tx_r;
  logic          tx_s;
  logic          busy_r;
  logic          busy_s;
  logic          done_r;
  logic          done_s;
  logic          accept_s;
  logic          bit_end_s;

  // Parity bit for a 7-bit word, polarity chosen by ODD_PAR.
  function automatic logic calc_parity(input logic [6:0] d);
    logic x;
    x = ^d;
    if (ODD_PAR != 0) begin
      calc_parity = ~x;
    end else begin
      calc_parity = x;
    end
  endfunction

  // Ready depends on rst_n directly so no word is taken while reset is asserted.
  assign in_ready  = rst_n & (state_r == ST_IDLE);
  assign accept_s  = in_valid & in_ready;
  assign bit_end_s = (baud_r == BAUD_LAST);

  // Next-state, counter and holding-register logic.
  always_comb begin
    state_s = state_r;
    baud_s  = baud_r;
    bit_s   = bit_r;
    hold_s  = hold_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_START;
          baud_s  = '0;
          bit_s   = 3'd0;
          hold_s  = {calc_parity(in_data), in_data};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
          baud_s  = '0;
        end else begin
          baud_s  = baud_r + CW'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          baud_s = '0;
          if (bit_r == 3'd6) begin
            state_s = ST_PARITY;
            bit_s   = 3'd0;
          end else begin
            bit_s   = bit_r + 3'd1;
          end
        end else begin
          baud_s = baud_r + CW'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s = ST_STOP;
          baud_s  = '0;
        end else begin
          baud_s  = baud_r + CW'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_s = ST_IDLE;
          baud_s  = '0;
        end else begin
          baud_s  = baud_r + CW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        baud_s  = '0;
        bit_s   = 3'd0;
      end
    endcase
  end

  // Output values for the next cycle, decoded from the next state so the
  // outputs themselves can be registered without adding latency.
  always_comb begin
    tx_s   = 1'b1;
    busy_s = (state_s != ST_IDLE);
    done_s = (state_s == ST_STOP) && (baud_s == BAUD_LAST);
    case (state_s)
      ST_IDLE:   tx_s = 1'b1;
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = hold_s[bit_s];
      ST_PARITY: tx_s = hold_s[7];
      ST_STOP:   tx_s = 1'b1;
      default:   tx_s = 1'b1;
    endcase
  end

  // State, counters, holding register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      baud_r  <= '0;
      bit_r   <= 3'd0;
      hold_r  <= 8'd0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      baud_r  <= baud_s;
      bit_r   <= bit_s;
      hold_r  <= hold_s;
      tx_r    <= tx_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign tx         = tx_r;
  assign tx_busy    = busy_r;
  assign frame_done = done_r;

`ifdef PARITY_TX_FRAME_CNT_EN
  logic [15:0] cnt_r;

  // Completed-frame counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= 16'd0;
    end else if (done_r) begin
      cnt_r <= cnt_r + 16'd1;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign frame_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_parity_tx.sv
module tb_parity_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_w [3];
  logic [6:0] data_w  [3];
  logic       ready_w [3];
  logic       tx_w    [3];
  logic       busy_w  [3];
  logic       done_w  [3];
  int         baud_of [3] = '{1, 1, 4};
  int         n_checks = 0;
  int         n_errors = 0;
`ifdef PARITY_TX_FRAME_CNT_EN
  logic [15:0] cnt_w [3];
`endif

  always #5 clk = ~clk;

  // u_dut0: odd parity, 1 cycle/bit; u_dut1: even parity, 1 cycle/bit;
  // u_dut2: odd parity, 4 cycles/bit
  parity_tx #(.ODD_PAR(1), .BAUD_DIV(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_w[0]), .in_data(data_w[0]),
    .in_ready(ready_w[0]), .tx(tx_w[0]), .tx_busy(busy_w[0]), .frame_done(done_w[0])
`ifdef PARITY_TX_FRAME_CNT_EN
    , .frame_cnt(cnt_w[0])
`endif
  );
  parity_tx #(.ODD_PAR(0), .BAUD_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_w[1]), .in_data(data_w[1]),
    .in_ready(ready_w[1]), .tx(tx_w[1]), .tx_busy(busy_w[1]), .frame_done(done_w[1])
`ifdef PARITY_TX_FRAME_CNT_EN
    , .frame_cnt(cnt_w[1])
`endif
  );
  parity_tx #(.ODD_PAR(1), .BAUD_DIV(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid_w[2]), .in_data(data_w[2]),
    .in_ready(ready_w[2]), .tx(tx_w[2]), .tx_busy(busy_w[2]), .frame_done(done_w[2])
`ifdef PARITY_TX_FRAME_CNT_EN
    , .frame_cnt(cnt_w[2])
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer a word from the next falling edge until accepted; returns 1 time
  // unit after the accepting edge (the first cycle of the start bit).
  task automatic send(input int k, input logic [6:0] d, input bit keep);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    valid_w[k] = 1'b1;
    data_w[k]  = d;
    for (int i = 0; i < 200; i++) begin
      if (ready_w[k]) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!keep) valid_w[k] = 1'b0;
    if (!ok) check($sformatf("send%0d timeout", k), 32'd0, 32'd1);
  endtask

  // Check every cycle of a frame starting now, then the following idle cycle.
  task automatic expect_frame(input int k, input logic [6:0] d, input logic p);
    logic [9:0] fr;
    int         baud;
    fr   = {1'b1, p, d, 1'b0};
    baud = baud_of[k];
    for (int n = 0; n < 10 * baud; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      check($sformatf("d%0d w%02h n%0d tx", k, d, n), 32'(tx_w[k]), 32'(fr[n / baud]));
      check($sformatf("d%0d w%02h n%0d done", k, d, n), 32'(done_w[k]),
            32'(n == 10 * baud - 1));
      check($sformatf("d%0d w%02h n%0d busy", k, d, n), 32'(busy_w[k]), 32'd1);
      check($sformatf("d%0d w%02h n%0d ready", k, d, n), 32'(ready_w[k]), 32'd0);
    end
    @(posedge clk);
    #1;
    check($sformatf("d%0d w%02h idle tx", k, d), 32'(tx_w[k]), 32'd1);
    check($sformatf("d%0d w%02h idle busy", k, d), 32'(busy_w[k]), 32'd0);
    check($sformatf("d%0d w%02h idle ready", k, d), 32'(ready_w[k]), 32'd1);
    check($sformatf("d%0d w%02h idle done", k, d), 32'(done_w[k]), 32'd0);
  endtask

  initial begin
    int bad;
    for (int k = 0; k < 3; k++) begin
      valid_w[k] = 1'b0;
      data_w[k]  = 7'h00;
    end

    // Reset state, sampled while rst_n is still low
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst%0d ready", k), 32'(ready_w[k]), 32'd0);
      check($sformatf("rst%0d tx", k), 32'(tx_w[k]), 32'd1);
      check($sformatf("rst%0d busy", k), 32'(busy_w[k]), 32'd0);
      check($sformatf("rst%0d done", k), 32'(done_w[k]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) check($sformatf("rel%0d ready", k), 32'(ready_w[k]), 32'd1);

    // Odd parity, one cycle per bit: 0,1,0,0,0,0,0,0,0,1 for 7'h01
    send(0, 7'h01, 1'b0);
    expect_frame(0, 7'h01, 1'b0);
    send(0, 7'h00, 1'b0);
    expect_frame(0, 7'h00, 1'b1);

    // Even parity
    send(1, 7'h03, 1'b0);
    expect_frame(1, 7'h03, 1'b0);
    send(1, 7'h7F, 1'b0);
    expect_frame(1, 7'h7F, 1'b1);

    // Back-to-back with valid held high, 4 cycles per bit
    send(2, 7'h55, 1'b1);
    data_w[2] = 7'h2A;              // changes while busy: must not disturb 7'h55
    expect_frame(2, 7'h55, 1'b1);   // ends in the single idle cycle
    @(posedge clk);
    #1;
    valid_w[2] = 1'b0;
    expect_frame(2, 7'h2A, 1'b0);

    // Reset during data bit 3 of 7'h33 (d3 = 0)
    send(2, 7'h33, 1'b0);
    repeat (16) begin
      @(posedge clk);
      #1;
    end
    check("mid d3 tx", 32'(tx_w[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid rst tx", 32'(tx_w[2]), 32'd1);
    check("mid rst busy", 32'(busy_w[2]), 32'd0);
    check("mid rst done", 32'(done_w[2]), 32'd0);
    check("mid rst ready", 32'(ready_w[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid rel ready", 32'(ready_w[2]), 32'd1);
    bad = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (done_w[2] !== 1'b0 || tx_w[2] !== 1'b1) bad++;
    end
    check("mid dropped quiet", 32'(bad), 32'd0);
    send(2, 7'h4C, 1'b0);
    expect_frame(2, 7'h4C, 1'b0);

    // New requests while busy are ignored
    send(2, 7'h12, 1'b0);
    fork
      expect_frame(2, 7'h12, 1'b1);
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          valid_w[2] = 1'b1;
          data_w[2]  = 7'(7'h40 + i);
          @(negedge clk);
          valid_w[2] = 1'b0;
        end
      end
    join

`ifdef PARITY_TX_FRAME_CNT_EN
    check("cnt2 after reset", 32'(cnt_w[2]), 32'd2);
    check("cnt0 after reset", 32'(cnt_w[0]), 32'd0);
    send(0, 7'h0A, 1'b0);
    expect_frame(0, 7'h0A, 1'b1);
    send(0, 7'h0B, 1'b0);
    expect_frame(0, 7'h0B, 1'b0);
    send(0, 7'h0C, 1'b0);
    expect_frame(0, 7'h0C, 1'b1);
    check("cnt0 three", 32'(cnt_w[0]), 32'd3);
    force u_dut0.cnt_r = 16'hFFFF;
    @(posedge clk);
    #1;
    release u_dut0.cnt_r;
    check("cnt0 preload", 32'(cnt_w[0]), 32'hFFFF);
    send(0, 7'h01, 1'b0);
    expect_frame(0, 7'h01, 1'b0);
    check("cnt0 wrap", 32'(cnt_w[0]), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
